neuron_mac_accumulator: RTL and testbench

- Parametrised, pipelined signed multiply-accumulate engine that computes one neuron dot-product per vector: sum(a_i*b_i) + bias.
- Successor to the single-shot DSP MAC test block. Adds vector framing (in_last), valid/ready handshakes on input and output, a wide internal accumulator, and optional output saturation.
- Sits between the pixel/weight fetch logic and the activation stage of the handwriting-recognition network.

---
 rtl/neuron_mac_accumulator_pkg.sv | 11 +
 rtl/neuron_mac_accumulator_mult_stage.sv | 41 ++++
 rtl/neuron_mac_accumulator.sv | 161 ++++++++++++++++
 tb/tb_neuron_mac_accumulator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_accumulator_pkg.sv
// Shared defaults for the neuron MAC datapath: operand/accumulator widths
// and the accept-to-result pipeline depth.
package neuron_mac_accumulator_pkg;

    localparam int DEF_A_W   = 18;
    localparam int DEF_B_W   = 18;
    localparam int DEF_ACC_W = 48;
    localparam int DEF_OUT_W = 32;
    localparam int MAC_LAT   = 3;

endpackage

// File: rtl/neuron_mac_accumulator_mult_stage.sv
// Two-register signed multiplier (operand register + product register),
// shaped to map onto a single DSP48 slice.
module mac_mult_stage #(
    parameter int A_W = 18,
    parameter int B_W = 18
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        i_en,
    input  logic signed [A_W-1:0]       i_a,
    input  logic signed [B_W-1:0]       i_b,
    output logic signed [A_W+B_W-1:0]   o_p
);

    logic signed [A_W-1:0]     r_a;
    logic signed [B_W-1:0]     r_b;
    logic signed [A_W+B_W-1:0] r_p;
    logic signed [A_W+B_W-1:0] w_a_ext;
    logic signed [A_W+B_W-1:0] w_b_ext;

    assign w_a_ext = (A_W+B_W)'(r_a);
    assign w_b_ext = (A_W+B_W)'(r_b);

    // Operand capture on accepted beats, then full-width product one cycle later.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_a <= {A_W{1'b0}};
            r_b <= {B_W{1'b0}};
            r_p <= {(A_W+B_W){1'b0}};
        end else begin
            if (i_en) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            r_p <= w_a_ext * w_b_ext;
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Pipelined signed dot-product engine: sum(a*b) + bias per framed vector,
// with valid/ready handshakes, one vector in flight, optional saturation.
module neuron_mac_accumulator
    import neuron_mac_accumulator_pkg::*;
#(
    parameter int A_W    = DEF_A_W,
    parameter int B_W    = DEF_B_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SAT_EN = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [A_W-1:0]     a,
    input  logic signed [B_W-1:0]     b,
    input  logic signed [ACC_W-1:0]   bias,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   out_data,
    output logic                      out_sat
);

    localparam int P_W = A_W + B_W;
    localparam logic signed [ACC_W-1:0] LP_SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LP_SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    w_accept;
    logic                    w_out_hs;
    logic                    w_busy_next;
    logic signed [P_W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [OUT_W-1:0] w_sat_data;
    logic                    w_sat_flag;

    logic                    r_first_pending;
    logic                    r_busy;
    logic                    r_in_ready;
    logic                    r_s1_valid, r_s1_first, r_s1_last;
    logic signed [ACC_W-1:0] r_s1_bias;
    logic                    r_s2_valid, r_s2_first, r_s2_last;
    logic signed [ACC_W-1:0] r_s2_bias;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_s3_done;
    logic                    r_out_valid;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_sat;

    assign w_accept    = in_valid & r_in_ready;
    assign w_out_hs    = r_out_valid & out_ready;
    assign w_busy_next = (w_accept & in_last) | (r_busy & ~w_out_hs);
    assign w_prod_ext  = ACC_W'(w_prod);

    mac_mult_stage #(.A_W(A_W), .B_W(B_W)) u_mult (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (w_accept),
        .i_a     (a),
        .i_b     (b),
        .o_p     (w_prod)
    );

    // Framing: busy spans last-beat acceptance until the result handshake.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_first_pending <= 1'b1;
            r_busy          <= 1'b0;
            r_in_ready      <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_in_ready <= ~w_busy_next;
            if (w_accept) begin
                r_first_pending <= in_last;
            end
        end
    end

    // S1/S2 sideband, kept in step with the multiplier's two registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_bias  <= {ACC_W{1'b0}};
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_bias  <= {ACC_W{1'b0}};
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_first <= r_first_pending;
                r_s1_last  <= in_last;
                if (r_first_pending) begin
                    r_s1_bias <= bias;
                end
            end
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_bias  <= r_s1_bias;
        end
    end

    // S3 accumulator: a first beat restarts from bias, bubbles leave it untouched.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc     <= {ACC_W{1'b0}};
            r_s3_done <= 1'b0;
        end else begin
            if (r_s2_valid) begin
                r_acc <= (r_s2_first ? r_s2_bias : r_acc) + w_prod_ext;
            end
            r_s3_done <= r_s2_valid & r_s2_last;
        end
    end

    // Clamp to the signed output range, or wrap to the low bits when disabled.
    always_comb begin
        w_sat_data = r_acc[OUT_W-1:0];
        w_sat_flag = 1'b0;
        if (SAT_EN != 0) begin
            if (r_acc > LP_SAT_MAX) begin
                w_sat_data = LP_SAT_MAX[OUT_W-1:0];
                w_sat_flag = 1'b1;
            end else if (r_acc < LP_SAT_MIN) begin
                w_sat_data = LP_SAT_MIN[OUT_W-1:0];
                w_sat_flag = 1'b1;
            end else begin
                w_sat_data = r_acc[OUT_W-1:0];
                w_sat_flag = 1'b0;
            end
        end else begin
            w_sat_data = r_acc[OUT_W-1:0];
            w_sat_flag = 1'b0;
        end
    end

    // Output register: loads once per vector and holds under backpressure.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {OUT_W{1'b0}};
            r_out_sat   <= 1'b0;
        end else if (r_s3_done) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sat_data;
            r_out_sat   <= w_sat_flag;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Directed bench: default 32-bit instance plus two 16-bit instances
// (saturating and wrapping) driven by the same stimulus.
module tb_neuron_mac_accumulator;
    import neuron_mac_accumulator_pkg::*;

    logic               clock;
    logic               reset_n;
    logic               in_valid;
    logic               in_last;
    logic               out_ready;
    logic signed [17:0] a;
    logic signed [17:0] b;
    logic signed [47:0] bias;

    logic               rdy32, rdy_s16, rdy_w16;
    logic               vld32, vld_s16, vld_w16;
    logic signed [31:0] dat32;
    logic signed [15:0] dat_s16, dat_w16;
    logic               sat32, sat_s16, sat_w16;

    int n_vec;
    int n_err;
    int lat;

    neuron_mac_accumulator #(.A_W(18), .B_W(18), .ACC_W(48), .OUT_W(32), .SAT_EN(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy32),
        .a(a), .b(b), .bias(bias), .in_last(in_last),
        .out_valid(vld32), .out_ready(out_ready), .out_data(dat32), .out_sat(sat32)
    );

    neuron_mac_accumulator #(.A_W(18), .B_W(18), .ACC_W(48), .OUT_W(16), .SAT_EN(1)) u_sat16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_s16),
        .a(a), .b(b), .bias(bias), .in_last(in_last),
        .out_valid(vld_s16), .out_ready(out_ready), .out_data(dat_s16), .out_sat(sat_s16)
    );

    neuron_mac_accumulator #(.A_W(18), .B_W(18), .ACC_W(48), .OUT_W(16), .SAT_EN(0)) u_wrap16 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_w16),
        .a(a), .b(b), .bias(bias), .in_last(in_last),
        .out_valid(vld_w16), .out_ready(out_ready), .out_data(dat_w16), .out_sat(sat_w16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one beat and holds it until it transfers; returns #1 after the accepting edge.
    task automatic send_beat(input int ta, input int tb, input longint tbias, input bit tlast);
        bit got;
        got      = 1'b0;
        a        = 18'(ta);
        b        = 18'(tb);
        bias     = 48'(tbias);
        in_last  = tlast;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rdy32) begin
                got = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (got) begin
            @(posedge clock);
            #1;
        end else begin
            check_eq("beat_accept_timeout", 64'(got), 64'(1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts edges from the last-beat acceptance until out_valid.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!vld32 && cycles < 20) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        check_eq("out_valid_seen", 64'(vld32), 64'(1));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check_eq("hs_out_valid_clr", 64'(vld32), 64'(0));
        check_eq("hs_in_ready_set", 64'(rdy32), 64'(1));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        a         = 18'sd0;
        b         = 18'sd0;
        bias      = 48'sd0;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_in_ready", 64'(rdy32), 64'(0));
        check_eq("rst_out_valid", 64'(vld32), 64'(0));
        check_eq("rst_out_data", dat32, 64'(0));
        check_eq("rst_out_sat", 64'(sat32), 64'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_eq("post_rst_in_ready", 64'(rdy32), 64'(1));

        // single beat: 10*20+30
        send_beat(10, 20, 30, 1'b1);
        check_eq("single_in_ready_low", 64'(rdy32), 64'(0));
        wait_result(lat);
        check_eq("single_latency", 64'(lat), 64'(MAC_LAT));
        check_eq("single_data", dat32, 64'(230));
        check_eq("single_sat", 64'(sat32), 64'(0));
        handshake();

        // three beats, bias only taken on the first: 2+6-20+3
        send_beat(1, 2, 3, 1'b0);
        send_beat(3, 2, 1000, 1'b0);
        send_beat(-4, 5, 1000, 1'b1);
        check_eq("three_in_ready_low", 64'(rdy32), 64'(0));
        wait_result(lat);
        check_eq("three_latency", 64'(lat), 64'(MAC_LAT));
        check_eq("three_data", dat32, -64'sd9);
        check_eq("three_in_ready_wait", 64'(rdy32), 64'(0));
        handshake();

        // same vector with two idle cycles between beats
        send_beat(1, 2, 3, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        send_beat(3, 2, 7, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        send_beat(-4, 5, 7, 1'b1);
        wait_result(lat);
        check_eq("bubble_latency", 64'(lat), 64'(MAC_LAT));
        check_eq("bubble_data", dat32, -64'sd9);
        handshake();

        // backpressure, with a stray beat offered while in_ready is low
        send_beat(10, 20, 30, 1'b1);
        wait_result(lat);
        check_eq("bp_data", dat32, 64'(230));
        a        = 18'sd100;
        b        = 18'sd100;
        bias     = 48'sd5000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check_eq("bp_hold_data", dat32, 64'(230));
            check_eq("bp_hold_valid", 64'(vld32), 64'(1));
            check_eq("bp_in_ready", 64'(rdy32), 64'(0));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake();
        send_beat(3, 2, 3, 1'b1);
        wait_result(lat);
        check_eq("b2b_latency", 64'(lat), 64'(MAC_LAT));
        check_eq("b2b_data", dat32, 64'(9));
        handshake();

        // 16-bit outputs: 300*300=90000
        send_beat(300, 300, 0, 1'b1);
        wait_result(lat);
        check_eq("big_pos_32", dat32, 64'(90000));
        check_eq("big_pos_32_sat", 64'(sat32), 64'(0));
        check_eq("sat16_pos", dat_s16, 64'(32767));
        check_eq("sat16_pos_flag", 64'(sat_s16), 64'(1));
        check_eq("wrap16_pos", dat_w16, 64'(24464));
        check_eq("wrap16_pos_flag", 64'(sat_w16), 64'(0));
        handshake();
        send_beat(-300, 300, 0, 1'b1);
        wait_result(lat);
        check_eq("big_neg_32", dat32, -64'sd90000);
        check_eq("sat16_neg", dat_s16, -64'sd32768);
        check_eq("sat16_neg_flag", 64'(sat_s16), 64'(1));
        check_eq("wrap16_neg", dat_w16, -64'sd24464);
        handshake();

        // reset in the middle of a vector discards the partial sum
        send_beat(5, 5, 100, 1'b0);
        send_beat(7, 7, 100, 1'b0);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check_eq("midrst_in_ready", 64'(rdy32), 64'(0));
        check_eq("midrst_out_valid", 64'(vld32), 64'(0));
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_eq("midrst_in_ready_after", 64'(rdy32), 64'(1));
        send_beat(1, 2, 3, 1'b1);
        wait_result(lat);
        check_eq("midrst_latency", 64'(lat), 64'(MAC_LAT));
        check_eq("midrst_data", dat32, 64'(5));
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
